// File: rtl/ramio_bram.sv
// ramio_bram: single-port block-RAM responder for the core's ramio bus.
// It completes instruction fetches, loads and stores. Byte, half and word
// accesses are right-aligned, and loads are zero- or sign-extended.
// Misaligned, out-of-range and combined read+write requests set a sticky
// error flag. The boot loader fills the RAM from flash through this same port.
//
// Parameters:
//   DepthWords  number of 32-bit words (power of two, >= 4)
//   ReadLatency cycles from request capture to data_out_ready (>= 1)
//   WriteCycles cycles busy stays high after a write is captured (>= 1)
//   InitFile    optional initial memory image name
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   enable          request valid
//   read_type[2:0]  bit2 = sign extend; [1:0] 01 byte, 10 half, 11 word
//   write_type[1:0] 01 byte, 10 half, 11 word, 00 no write
//   address[31:0]   byte address
//   data_in[31:0]   write data, right-aligned
//   data_out[31:0]  read result, right-aligned and extended
//   data_out_ready  data_out is valid for the request currently presented
//   busy            a write is being captured or is still in progress
//   error           sticky request-error flag
//   led[3:0]        only when RAMIO_BRAM_LED_EN is defined. It is a register
//                   mapped at word 0x3FFF_FFFF and is loaded by a byte write
//                   to lane 3.
`timescale 1ns/1ps

module ramio_bram #(
   parameter int    DepthWords  = 1024,
   parameter int    ReadLatency = 1,
   parameter int    WriteCycles = 1,
   parameter string InitFile    = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [2:0]  read_type,
   input  logic [1:0]  write_type,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        data_out_ready,
   output logic        busy,
   output logic        error
`ifdef RAMIO_BRAM_LED_EN
   ,
   output logic [3:0]  led
`endif
);

   localparam int AW      = $clog2(DepthWords);
   localparam int CntMax  = (ReadLatency > WriteCycles) ? ReadLatency : WriteCycles;
   localparam int CW      = $clog2(CntMax + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   cnt;
   logic            prev_en;

   // Latched request, used to tell a held request from a new one.
   logic            lat_valid;
   logic [31:0]     lat_addr;
   logic [2:0]      lat_rt;
   logic [1:0]      lat_wt;
   logic            lat_ok;
   logic            lat_led;

   logic [31:0]     mem [DepthWords];
   logic [3:0]      mem_be;
   logic [31:0]     mem_wdata;

   logic            req_rd;
   logic            req_wr;
   logic            req_match;
   logic            new_req;
   logic            req_led;
   logic            in_range;
   logic            misaligned;
   logic            addr_ok;
   logic            req_error;
   logic [1:0]      req_size;
   logic            start;
   logic            start_wr;
   logic            start_rd;
   logic [31:0]     rd_word;
   logic [31:0]     led_word;

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   assign req_rd    = (read_type[1:0] != 2'b00);
   assign req_wr    = (write_type != 2'b00);
   assign req_match = lat_valid && (address == lat_addr) &&
                      (read_type == lat_rt) && (write_type == lat_wt);
   // The first cycle after enable was low always counts as a new request,
   // even if the inputs equal the latched request.
   assign new_req   = enable && (!prev_en || !req_match);

`ifdef RAMIO_BRAM_LED_EN
   assign req_led  = (address[31:2] == 30'h3FFF_FFFF);
   assign led_word = {led, 28'h0};
`else
   assign req_led  = 1'b0;
   assign led_word = 32'h0;
`endif

   // A combined read+write request is treated as a write, so the write
   // size governs alignment.
   assign req_size   = req_wr ? write_type : read_type[1:0];
   assign misaligned = ((req_size == 2'b10) && address[0]) ||
                       ((req_size == 2'b11) && (address[1:0] != 2'b00));
   assign in_range   = ((address[31:2] >> AW) == 30'h0);
   assign addr_ok    = !misaligned && (in_range || req_led);
   assign req_error  = (req_rd && req_wr) || !addr_ok;

   // Done behaves exactly like Idle when a new request arrives.
   assign start    = new_req && ((state == S_IDLE) || (state == S_DONE));
   assign start_wr = start && req_wr;
   assign start_rd = start && !req_wr && req_rd;

   // ---------------------------------------------------------------------
   // Next state and handshake outputs
   // ---------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start_wr)      next_state = S_WRITE;
            else if (start_rd) next_state = S_READ;
         end
         S_READ: begin
            if (cnt == '0) next_state = S_DONE;
         end
         S_WRITE: begin
            if (cnt == '0) next_state = S_DONE;
         end
         S_DONE: begin
            if (!enable)       next_state = S_IDLE;
            else if (start_wr) next_state = S_WRITE;
            else if (start_rd) next_state = S_READ;
            else if (new_req)  next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign busy           = (state == S_WRITE) || start_wr;
   // Gated combinationally, so ready drops in the same cycle that the core
   // moves to a different request.
   assign data_out_ready = (state == S_DONE) && enable && req_match;

   // ---------------------------------------------------------------------
   // Lane-masked write port. A write commits on its capture edge.
   // ---------------------------------------------------------------------
   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = data_in;
      case (write_type)
         2'b01: begin
            mem_be    = 4'b0001 << address[1:0];
            mem_wdata = {4{data_in[7:0]}};
         end
         2'b10: begin
            mem_be    = address[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{data_in[15:0]}};
         end
         2'b11:   mem_be = 4'b1111;
         default: mem_be = 4'b0000;
      endcase
      if (!(start_wr && addr_ok && !req_led)) mem_be = 4'b0000;
   end

   // NOTE: the RAM array has no reset. This lets it map onto block RAM,
   // and its contents survive a core reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_be[i]) mem[address[AW+1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   // ---------------------------------------------------------------------
   // Read extraction: shift the addressed lane down, then extend it.
   // Word reads ignore the sign bit.
   // ---------------------------------------------------------------------
   function automatic logic [31:0] extract(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  rt);
      logic [31:0] result;
      case (rt[1:0])
         2'b01: result = {{24{rt[2] & word[{lane, 3'b111}]}},
                          word[{lane, 3'b000} +: 8]};
         2'b10: result = {{16{rt[2] & word[{lane[1], 4'b1111}]}},
                          word[{lane[1], 4'b0000} +: 16]};
         default: result = word;
      endcase
      return result;
   endfunction

   assign rd_word = lat_led ? led_word : mem[lat_addr[AW+1:2]];

   // ---------------------------------------------------------------------
   // Control state, latched request, read data and sticky error
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every
   // register then samples the pre-edge values, whatever the order of the
   // statements below.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         prev_en   <= 1'b0;
         lat_valid <= 1'b0;
         lat_addr  <= '0;
         lat_rt    <= '0;
         lat_wt    <= '0;
         lat_ok    <= 1'b0;
         lat_led   <= 1'b0;
         data_out  <= '0;
         error     <= 1'b0;
      end else begin
         state   <= next_state;
         prev_en <= enable;

         if (start) begin
            lat_valid <= 1'b1;
            lat_addr  <= address;
            lat_rt    <= read_type;
            lat_wt    <= write_type;
            lat_ok    <= addr_ok;
            lat_led   <= req_led;
            if ((req_rd || req_wr) && req_error) error <= 1'b1;
         end

         if (start_wr)
            cnt <= CW'(WriteCycles - 1);
         else if (start_rd)
            cnt <= CW'(ReadLatency - 1);
         else if (((state == S_READ) || (state == S_WRITE)) && (cnt != '0))
            cnt <= cnt - 1'b1;

         // A rejected read still completes with normal timing and
         // returns zero.
         if ((state == S_READ) && (cnt == '0))
            data_out <= lat_ok ? extract(rd_word, lat_addr[1:0], lat_rt) : 32'h0;
      end
   end

`ifdef RAMIO_BRAM_LED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         led <= '0;
      else if (start_wr && req_led && (write_type == 2'b01) && (address[1:0] == 2'b11))
         led <= data_in[3:0];
   end
`endif

endmodule

// File: tb/tb_ramio_bram.sv
// tb_ramio_bram: self-checking bench for ramio_bram.
// The driver issues one request at a time. It updates a byte-array model of
// the memory and pushes the expected response into a scoreboard queue.
// A monitor on the falling edge pops one entry each time data_out_ready
// rises. It compares read data, latency, the number of busy cycles, the
// sticky error flag and (with RAMIO_BRAM_LED_EN) the LED register.
// Ports: none (top-level bench).
`timescale 1ns/1ps

module tb_ramio_bram;

   localparam int DEPTH = 64;
   localparam int RL    = 3;
   localparam int WC    = 2;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      int          lat;
      int          nbusy;
      bit          err;
      logic [3:0]  led;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  read_type = '0;
   logic [1:0]  write_type = '0;
   logic [31:0] address = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic        busy;
   logic        error;
`ifdef RAMIO_BRAM_LED_EN
   logic [3:0]  led;
`endif

   ramio_bram #(
      .DepthWords (DEPTH),
      .ReadLatency(RL),
      .WriteCycles(WC),
      .InitFile   ("")
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .read_type     (read_type),
      .write_type    (write_type),
      .address       (address),
      .data_in       (data_in),
      .data_out      (data_out),
      .data_out_ready(data_out_ready),
      .busy          (busy),
      .error         (error)
`ifdef RAMIO_BRAM_LED_EN
      ,
      .led           (led)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0]  bmem [DEPTH*4];
   logic [3:0]  led_m = '0;
   bit          err_m = 1'b0;
   exp_t        sb_q[$];

   bit          last_valid = 1'b0;
   logic [31:0] last_a;
   logic [2:0]  last_rt;
   logic [1:0]  last_wt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit is_led_addr(input logic [31:0] a);
`ifdef RAMIO_BRAM_LED_EN
      return a[31:2] == 30'h3FFF_FFFF;
`else
      return (a != a);
`endif
   endfunction

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
   endfunction

   function automatic bit addr_ok(input logic [31:0] a, input int n);
      return ((a % 32'(n)) == 0) && (((a / 4) < DEPTH) || is_led_addr(a));
   endfunction

   function automatic logic [7:0] model_byte(input logic [31:0] x);
      logic [31:0] w;
      if (is_led_addr(x)) begin
         w = {led_m, 28'h0};
         return 8'(w >> (8 * int'(x % 4)));
      end
      return bmem[int'(x)];
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit sgn);
      logic [31:0] raw;
      raw = '0;
      for (int i = 0; i < n; i++) raw = raw | (32'(model_byte(a + 32'(i))) << (8 * i));
      if (sgn && n < 4 && raw[8*n-1]) raw = raw | (32'hFFFF_FFFF << (8 * n));
      return raw;
   endfunction

   task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
      if (is_led_addr(a)) begin
         if (n == 1 && a[1:0] == 2'b11) led_m = d[3:0];
      end else begin
         for (int i = 0; i < n; i++) bmem[int'(a) + i] = 8'(d >> (8 * i));
      end
   endtask

   // Issue one request, wait for its ready, optionally hold it for a few
   // more cycles, and return one cycle later at posedge+1.
   task automatic issue(input logic [31:0] a, input logic [2:0] rt, input logic [1:0] wt,
                        input logic [31:0] d, input int gap, input int hold);
      exp_t e;
      int   n;
      int   g;
      bit   ok;
      bit   got;
      g = gap;
      if (g == 0 && last_valid && a == last_a && rt == last_rt && wt == last_wt) g = 1;
      n  = nbytes((wt != 2'b00) ? wt : rt[1:0]);
      ok = addr_ok(a, n);
      if (!ok || (rt[1:0] != 2'b00 && wt != 2'b00)) err_m = 1'b1;
      e.is_read = 1'b0;
      e.data    = '0;
      if (wt != 2'b00) begin
         if (ok) model_write(a, n, d);
         e.lat   = WC + 1;
         e.nbusy = WC + 1;
      end else begin
         e.is_read = 1'b1;
         e.data    = ok ? model_read(a, n, rt[2]) : 32'h0;
         e.lat     = RL + 1;
         e.nbusy   = 0;
      end
      e.err = err_m;
      e.led = led_m;
      sb_q.push_back(e);

      if (g > 0) begin
         enable = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
      end
      address    = a;
      read_type  = rt;
      write_type = wt;
      data_in    = d;
      enable     = 1'b1;
      last_valid = 1'b1;
      last_a     = a;
      last_rt    = rt;
      last_wt    = wt;

      got = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         if (data_out_ready) got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: addr 0x%08h rt %0d wt %0d, no ready within 64 cycles, required ready", a, rt, wt);
      end
      repeat (hold + 1) begin @(posedge clk); #1; end
   endtask

   // Monitor: one scoreboard entry per rising edge of data_out_ready.
   int   mon_low = 0;
   int   mon_busy = 0;
   bit   mon_prev = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_low  = 0;
         mon_busy = 0;
         mon_prev = 1'b0;
      end else begin
         if (busy) mon_busy++;
         if (enable && !data_out_ready) mon_low++;
         if (data_out_ready && !mon_prev) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ready: got ready with empty scoreboard, required no ready");
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.is_read) check("read_data", data_out, mon_e.data);
               check("latency", 32'(mon_low), 32'(mon_e.lat));
               check("busy_cycles", 32'(mon_busy), 32'(mon_e.nbusy));
               check("error", {31'h0, error}, {31'h0, mon_e.err});
`ifdef RAMIO_BRAM_LED_EN
               check("led", {28'h0, led}, {28'h0, mon_e.led});
`endif
            end
            mon_low  = 0;
            mon_busy = 0;
         end
         mon_prev = data_out_ready;
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_out", data_out, 32'h0);
      check("rst_ready", {31'h0, data_out_ready}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_error", {31'h0, error}, 32'h0);
`ifdef RAMIO_BRAM_LED_EN
      check("rst_led", {28'h0, led}, 32'h0);
`endif
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Prefill every word so that later reads hit defined contents.
      for (int w = 0; w < DEPTH; w++) issue(32'(w * 4), 3'b000, 2'b11, $urandom, 0, 0);

      // Word store, then word load held for an extra cycle
      issue(32'h10, 3'b000, 2'b11, 32'hDEAD_BEEF, 0, 0);
      issue(32'h10, 3'b011, 2'b00, 32'h0, 0, 1);
      // Byte store, then signed and unsigned byte loads
      issue(32'h13, 3'b000, 2'b01, 32'h80, 0, 0);
      issue(32'h13, 3'b101, 2'b00, 32'h0, 0, 0);
      issue(32'h13, 3'b001, 2'b00, 32'h0, 0, 0);
      issue(32'h10, 3'b011, 2'b00, 32'h0, 1, 0);
      // Half-word store, then LH of the other half and LHU
      issue(32'h20, 3'b000, 2'b11, 32'h0, 0, 0);
      issue(32'h22, 3'b000, 2'b10, 32'h1234, 0, 0);
      issue(32'h20, 3'b110, 2'b00, 32'h0, 0, 0);
      issue(32'h22, 3'b010, 2'b00, 32'h0, 0, 0);
      // Held write must not trigger a second write
      issue(32'h30, 3'b000, 2'b11, 32'h5555_AAAA, 0, 3);
      // Held load, then an address change with enable kept high
      issue(32'h10, 3'b011, 2'b00, 32'h0, 0, 2);
      issue(32'h40, 3'b011, 2'b00, 32'h0, 0, 0);
      // Misaligned half store: memory unchanged, error set
      issue(32'h21, 3'b000, 2'b10, 32'h5678, 0, 0);
      issue(32'h20, 3'b011, 2'b00, 32'h0, 0, 0);
      // Read+write together: write performed, error stays set
      issue(32'h24, 3'b011, 2'b11, 32'h1122_3344, 0, 0);
      issue(32'h24, 3'b011, 2'b00, 32'h0, 0, 0);

      // Reset while a write is busy. The write already committed on its
      // capture edge.
      address    = 32'h34;
      read_type  = 3'b000;
      write_type = 2'b11;
      data_in    = 32'hCAFE_F00D;
      enable     = 1'b1;
      model_write(32'h34, 4, 32'hCAFE_F00D);
      @(negedge clk);
      check("wr_capture_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      check("wr_state_busy", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("midrst_data_out", data_out, 32'h0);
      check("midrst_ready", {31'h0, data_out_ready}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_error", {31'h0, error}, 32'h0);
      err_m = 1'b0;
      led_m = '0;
      last_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      issue(32'h10, 3'b011, 2'b00, 32'h0, 0, 0);
      issue(32'h34, 3'b011, 2'b00, 32'h0, 0, 0);

      // LED register: this address is out of range when the feature is off
      issue(32'hFFFF_FFFF, 3'b000, 2'b01, 32'h05, 0, 0);
      issue(32'hFFFF_FFFC, 3'b011, 2'b00, 32'h0, 0, 0);
      issue(32'hFFFF_FFFF, 3'b001, 2'b00, 32'h0, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 300; k++) begin
         int          r;
         int          kind;
         logic [1:0]  sz;
         logic [2:0]  rt;
         logic [1:0]  wt;
         logic [31:0] a;
         logic [1:0]  lane;
         r    = $urandom_range(0, 99);
         kind = $urandom_range(0, 19);
         sz   = 2'($urandom_range(1, 3));
         lane = (sz == 2'b01) ? 2'($urandom_range(0, 3)) :
                (sz == 2'b10) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
         if (r < 80)
            a = {24'h0, 6'($urandom_range(0, DEPTH - 1)), lane};
         else if (r < 88)
            a = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
         else if (r < 95)
            a = {22'($urandom_range(DEPTH, DEPTH + 200)), 8'h0} | 32'(lane);
         else
            a = {30'h3FFF_FFFF, lane};
         if (kind < 10) begin
            rt = {1'($urandom_range(0, 1)), sz};
            wt = 2'b00;
         end else if (kind < 19) begin
            rt = 3'b000;
            wt = sz;
         end else begin
            rt = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
            wt = sz;
         end
         issue(a, rt, wt, $urandom, $urandom_range(0, 1), $urandom_range(0, 2));
      end

      enable = 1'b0;
      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
